turn_scheduler: RTL and testbench

TURN_SCHEDULER -- requirements
Module: turn_scheduler

---
 rtl/ttt_pkg.sv | 24 ++
 rtl/turn_timer.sv | 38 +++
 rtl/turn_scheduler.sv | 146 ++++++++++++++
 tb/tb_turn_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe turn scheduler: FSM states, player
// codes, result codes and board size.
package ttt_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_MOVE = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_SETTLE    = 3'd2,
      ST_CHECK     = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_e;

   localparam logic [1:0] PLAYER_NONE = 2'b00;
   localparam logic [1:0] PLAYER_X    = 2'b01;
   localparam logic [1:0] PLAYER_O    = 2'b10;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_X    = 2'b01;
   localparam logic [1:0] WIN_O    = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam int NUM_CELLS = 9;

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: reloads to TURN_SECONDS, counts down on ticks while
// enabled and flags the tick that takes the count from 1 to 0.
module turn_timer #(
   parameter int TURN_SECONDS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic       enable_i,
   input  logic       tick_i,
   output logic [3:0] count_o,
   output logic       expire_o
);

   logic [3:0] count_q;
   logic [3:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = 4'(TURN_SECONDS);
      end else if (enable_i && tick_i && (count_q != 4'd0)) begin
         count_d = count_q - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 4'(TURN_SECONDS);
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o  = count_q;
   assign expire_o = enable_i && tick_i && (count_q == 4'd1);

endmodule

// File: rtl/turn_scheduler.sv
// Tic-tac-toe turn scheduler: accepts or rejects cursor moves, auto-plays the
// lowest free cell on timeout, alternates turns and halts on a game result.
module turn_scheduler
   import ttt_pkg::*;
#(
   parameter int TURN_SECONDS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1s,
   input  logic       sel_pulse,
   input  logic [3:0] cursor,
   input  logic [8:0] occupied,
   input  logic [1:0] win_code,
   output logic       play_x,
   output logic       play_o,
   output logic [3:0] move_pos,
   output logic [1:0] turn,
   output logic [3:0] seconds_left,
   output logic       reject,
   output logic       game_over,
   output logic [2:0] state_dbg
);

   // sel_pulse is a one-cycle request with no back-pressure: it is acted on
   // only in WAIT_MOVE, and answered one cycle later by either a single
   // play_x/play_o strobe (with move_pos valid alongside it) or a reject pulse.

   state_e     state_q, state_d;
   logic [1:0] turn_q, turn_d;
   logic [3:0] move_pos_q, move_pos_d;
   logic       play_x_q, play_x_d;
   logic       play_o_q, play_o_d;
   logic       reject_q, reject_d;

   logic       cursor_ok;
   logic       free_found;
   logic [3:0] free_cell;
   logic       timer_load;
   logic       timer_en;
   logic       timer_expire;
   logic [3:0] timer_count;

   always_comb begin
      cursor_ok  = 1'b0;
      free_found = 1'b0;
      free_cell  = 4'd0;
      for (int k = 1; k <= NUM_CELLS; k++) begin
         if ((cursor == 4'(k)) && !occupied[k-1]) cursor_ok = 1'b1;
      end
      // Scan downward so the last hit is the lowest-numbered free cell.
      for (int k = NUM_CELLS; k >= 1; k--) begin
         if (!occupied[k-1]) begin
            free_found = 1'b1;
            free_cell  = 4'(k);
         end
      end
   end

   turn_timer #(
      .TURN_SECONDS(TURN_SECONDS)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (timer_load),
      .enable_i (timer_en),
      .tick_i   (tick_1s),
      .count_o  (timer_count),
      .expire_o (timer_expire)
   );

   always_comb begin
      state_d    = state_q;
      turn_d     = turn_q;
      move_pos_d = move_pos_q;
      play_x_d   = 1'b0;
      play_o_d   = 1'b0;
      reject_d   = 1'b0;
      timer_load = 1'b0;
      timer_en   = 1'b0;
      case (state_q)
         ST_WAIT_MOVE: begin
            timer_en = 1'b1;
            reject_d = sel_pulse && !cursor_ok;
            if (sel_pulse && cursor_ok) begin
               state_d    = ST_ISSUE;
               move_pos_d = cursor;
               play_x_d   = (turn_q == PLAYER_X);
               play_o_d   = (turn_q == PLAYER_O);
            end else if (timer_expire) begin
               if (free_found) begin
                  state_d    = ST_ISSUE;
                  move_pos_d = free_cell;
                  play_x_d   = (turn_q == PLAYER_X);
                  play_o_d   = (turn_q == PLAYER_O);
               end else begin
                  state_d = ST_GAME_OVER;
                  turn_d  = PLAYER_NONE;
               end
            end
         end
         ST_ISSUE:  state_d = ST_SETTLE;
         ST_SETTLE: state_d = ST_CHECK;
         ST_CHECK: begin
            if (win_code != WIN_NONE) begin
               state_d = ST_GAME_OVER;
               turn_d  = PLAYER_NONE;
            end else begin
               state_d    = ST_WAIT_MOVE;
               turn_d     = (turn_q == PLAYER_X) ? PLAYER_O : PLAYER_X;
               timer_load = 1'b1;
            end
         end
         ST_GAME_OVER: state_d = ST_GAME_OVER;
         default:      state_d = ST_WAIT_MOVE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_WAIT_MOVE;
         turn_q     <= PLAYER_X;
         move_pos_q <= 4'd0;
         play_x_q   <= 1'b0;
         play_o_q   <= 1'b0;
         reject_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         turn_q     <= turn_d;
         move_pos_q <= move_pos_d;
         play_x_q   <= play_x_d;
         play_o_q   <= play_o_d;
         reject_q   <= reject_d;
      end
   end

   assign play_x       = play_x_q;
   assign play_o       = play_o_q;
   assign move_pos     = move_pos_q;
   assign reject       = reject_q;
   assign turn         = turn_q;
   assign game_over    = (state_q == ST_GAME_OVER);
   assign seconds_left = (state_q == ST_GAME_OVER) ? 4'd0 : timer_count;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler: move acceptance, rejects, timeouts,
// game over and reset behaviour, with hand-computed expectations.
module tb_turn_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_1s;
   logic       sel_pulse;
   logic [3:0] cursor;
   logic [8:0] occupied;
   logic [1:0] win_code;
   logic       play_x;
   logic       play_o;
   logic [3:0] move_pos;
   logic [1:0] turn;
   logic [3:0] seconds_left;
   logic       reject;
   logic       game_over;
   logic [2:0] state_dbg;

   int checks = 0;
   int errors = 0;

   always #20 clk = ~clk;

   turn_scheduler #(.TURN_SECONDS(10)) dut (
      .clk          (clk),
      .rst          (rst),
      .tick_1s      (tick_1s),
      .sel_pulse    (sel_pulse),
      .cursor       (cursor),
      .occupied     (occupied),
      .win_code     (win_code),
      .play_x       (play_x),
      .play_o       (play_o),
      .move_pos     (move_pos),
      .turn         (turn),
      .seconds_left (seconds_left),
      .reject       (reject),
      .game_over    (game_over),
      .state_dbg    (state_dbg)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1s = 1'b1;
         step();
         tick_1s = 1'b0;
         step();
      end
   endtask

   initial begin
      rst = 1'b1; tick_1s = 1'b0; sel_pulse = 1'b0;
      cursor = 4'd0; occupied = 9'h000; win_code = 2'b00;
      #50;
      chk("rst_turn", 32'(turn), 32'h1);
      chk("rst_secs", 32'(seconds_left), 32'd10);
      chk("rst_pos", 32'(move_pos), 32'd0);
      chk("rst_strobes", {29'd0, play_x, play_o, reject}, 32'd0);
      chk("rst_game_over", 32'(game_over), 32'd0);
      step();
      rst = 1'b0;
      step();

      // X plays cell 5
      cursor = 4'd5; sel_pulse = 1'b1;
      step();
      sel_pulse = 1'b0;
      chk("x5_play_x", 32'(play_x), 32'd1);
      chk("x5_play_o", 32'(play_o), 32'd0);
      chk("x5_pos", 32'(move_pos), 32'd5);
      step();
      chk("x5_strobe_one_cycle", 32'(play_x), 32'd0);
      occupied = 9'h010;
      step();
      chk("x5_turn_still_x", 32'(turn), 32'h1);
      step();
      chk("x5_turn_o", 32'(turn), 32'h2);
      chk("x5_secs_reload", 32'(seconds_left), 32'd10);

      // O: two ticks, then rejects for occupied and invalid cursors
      tick_n(2);
      chk("o_secs_8", 32'(seconds_left), 32'd8);
      cursor = 4'd5; sel_pulse = 1'b1;
      step();
      sel_pulse = 1'b0;
      chk("rej_occ_reject", 32'(reject), 32'd1);
      chk("rej_occ_strobes", {30'd0, play_x, play_o}, 32'd0);
      chk("rej_occ_turn", 32'(turn), 32'h2);
      chk("rej_occ_secs", 32'(seconds_left), 32'd8);
      step();
      chk("rej_one_cycle", 32'(reject), 32'd0);
      cursor = 4'd0; sel_pulse = 1'b1;
      step();
      sel_pulse = 1'b0;
      chk("rej_cursor0", 32'(reject), 32'd1);
      cursor = 4'd12; sel_pulse = 1'b1;
      step();
      sel_pulse = 1'b0;
      chk("rej_cursor12", 32'(reject), 32'd1);
      chk("rej_secs_kept", 32'(seconds_left), 32'd8);

      // O plays cell 1
      cursor = 4'd1; sel_pulse = 1'b1;
      step();
      sel_pulse = 1'b0;
      chk("o1_play_o", 32'(play_o), 32'd1);
      chk("o1_play_x", 32'(play_x), 32'd0);
      chk("o1_pos", 32'(move_pos), 32'd1);
      step(); step(); step();
      chk("o1_turn_x", 32'(turn), 32'h1);

      // X times out with cells 1,2 taken -> auto cell 3
      occupied = 9'h003;
      tick_n(9);
      chk("to_secs_1", 32'(seconds_left), 32'd1);
      chk("to_no_early_strobe", 32'(play_x), 32'd0);
      tick_1s = 1'b1;
      step();
      tick_1s = 1'b0;
      chk("to_play_x", 32'(play_x), 32'd1);
      chk("to_pos_3", 32'(move_pos), 32'd3);
      chk("to_secs_0", 32'(seconds_left), 32'd0);
      occupied = 9'h007;
      step(); step(); step();
      chk("to_turn_o", 32'(turn), 32'h2);
      chk("to_secs_reload", 32'(seconds_left), 32'd10);

      // O: valid cursor 7 coincides with expiring tick
      tick_n(9);
      tick_1s = 1'b1; sel_pulse = 1'b1; cursor = 4'd7;
      step();
      tick_1s = 1'b0; sel_pulse = 1'b0;
      chk("race_play_o", 32'(play_o), 32'd1);
      chk("race_pos_7", 32'(move_pos), 32'd7);
      chk("race_no_reject", 32'(reject), 32'd0);
      occupied = 9'h047;
      step(); step(); step();
      chk("race_turn_x", 32'(turn), 32'h1);

      // X: invalid cursor coincides with expiring tick -> timeout plus reject
      tick_n(9);
      tick_1s = 1'b1; sel_pulse = 1'b1; cursor = 4'd1;
      step();
      tick_1s = 1'b0; sel_pulse = 1'b0;
      chk("race_inv_reject", 32'(reject), 32'd1);
      chk("race_inv_play_x", 32'(play_x), 32'd1);
      chk("race_inv_pos_4", 32'(move_pos), 32'd4);
      occupied = 9'h04F;
      step(); step(); step();
      chk("race_inv_turn_o", 32'(turn), 32'h2);

      // O plays 9, X win reported during SETTLE/CHECK
      cursor = 4'd9; sel_pulse = 1'b1;
      step();
      sel_pulse = 1'b0;
      chk("win_play_o", 32'(play_o), 32'd1);
      win_code = 2'b01;
      occupied = 9'h14F;
      step(); step(); step();
      chk("win_game_over", 32'(game_over), 32'd1);
      chk("win_turn_none", 32'(turn), 32'h0);
      chk("win_secs_0", 32'(seconds_left), 32'd0);
      cursor = 4'd8; sel_pulse = 1'b1; tick_1s = 1'b1;
      step();
      sel_pulse = 1'b0; tick_1s = 1'b0;
      chk("go_ignored", {29'd0, play_x, play_o, reject}, 32'd0);
      step();
      chk("go_held", 32'(game_over), 32'd1);
      rst = 1'b1;
      #5;
      chk("go_rst_turn", 32'(turn), 32'h1);
      chk("go_rst_game_over", 32'(game_over), 32'd0);
      occupied = 9'h000; win_code = 2'b00;
      step();
      rst = 1'b0;
      step();

      // Reset during ISSUE kills the strobe
      cursor = 4'd2; sel_pulse = 1'b1;
      step();
      sel_pulse = 1'b0;
      chk("issue_play_x", 32'(play_x), 32'd1);
      #5 rst = 1'b1;
      #1;
      chk("issue_rst_strobe", {30'd0, play_x, play_o}, 32'd0);
      chk("issue_rst_secs", 32'(seconds_left), 32'd10);
      chk("issue_rst_pos", 32'(move_pos), 32'd0);
      step();
      rst = 1'b0;
      step(); step();
      chk("issue_rst_no_late", {30'd0, play_x, play_o}, 32'd0);

      // Timeout with full board goes straight to game over
      occupied = 9'h1FF;
      tick_n(10);
      chk("full_game_over", 32'(game_over), 32'd1);
      chk("full_no_strobe", {30'd0, play_x, play_o}, 32'd0);
      chk("full_turn_none", 32'(turn), 32'h0);
      chk("full_secs_0", 32'(seconds_left), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
